// File: rtl/fifo2.sv
// Two-entry FIFO holding one output's words: count, read pointer and two data slots.
// Latency: a word pushed at edge k is at the head from edge k; pop advances the head.
// Backpressure: full is asserted at two entries and a push while full is ignored.
module fifo2 #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] head_data
);

    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [width-1:0] slot [2];

    // Status flags, guarded handshakes and the write slot derived from the read pointer.
    always_comb begin
        full    = (count == 2'd2);
        empty   = (count == 2'd0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_ptr  = rd_ptr ^ count[0];
    end

    // Head word; when empty the slot just behind the read pointer is the last popped word.
    always_comb begin
        head_data = empty ? slot[~rd_ptr] : slot[rd_ptr];
    end

    // Occupancy, pointer and slot storage; reset clears everything so stale words cannot leak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            rd_ptr  <= 1'b0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_data;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// Steers each accepted word to output 0 or 1 by choose_bit, each output buffered by a fifo2.
// Latency: a word accepted at edge k is valid on its output from edge k (1 cycle minimum).
// Backpressure: in_ready drops only when the selected output's buffer is full; never from out*_ready.
module demux2_stream #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] input_data,
    input  logic             choose_bit,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [width-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [width-1:0] out1_data
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic accept;
    logic push0;
    logic push1;
    logic pop0;
    logic pop1;

    // Ready mux on the destination, push decode and output valid/pop mapping.
    // A full buffer refuses even while being popped: there is no pass-through path.
    always_comb begin
        in_ready   = !rst && (choose_bit ? !full1 : !full0);
        accept     = in_valid && in_ready;
        push0      = accept && !choose_bit;
        push1      = accept && choose_bit;
        out0_valid = !empty0;
        out1_valid = !empty1;
        pop0       = out0_valid && out0_ready;
        pop1       = out1_valid && out1_ready;
    end

    fifo2 #(.width(width)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (input_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head_data (out0_data)
    );

    fifo2 #(.width(width)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (input_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head_data (out1_data)
    );

    // A refused offer must be held unchanged until it is taken.
    property p_producer_stable;
        @(posedge clk) disable iff (rst)
            (!rst && in_valid && !in_ready) |=>
                (in_valid && $stable(input_data) && $stable(choose_bit));
    endproperty
    a_producer_stable: assert property (p_producer_stable);

endmodule
